// File: rtl/unidade_controle_exp2_if.sv
// Control/status bundle between the Experiencia 2 control unit and its environment.
// master = control unit side; slave = datapath plus the start requester.
interface unidade_controle_exp2_if;
  logic       iniciar;
  logic       modo;
  logic       fim;
  logic       igual;
  logic       zera;
  logic       carrega;
  logic       conta;
  logic       pronto;
  logic       achou;
  logic [3:0] db_estado;

  modport master (
    input  iniciar, modo, fim, igual,
    output zera, carrega, conta, pronto, achou, db_estado
  );

  modport slave (
    output iniciar, modo, fim, igual,
    input  zera, carrega, conta, pronto, achou, db_estado
  );
endinterface

// File: rtl/unidade_controle_exp2.sv
// Control FSM for the Experiencia 2 counter/comparator datapath: one search or load-and-count run per iniciar.
// Moore outputs except conta, which is Mealy on fim/igual so the counter freezes on the matching value.
module unidade_controle_exp2 #(
  parameter int CICLOS_PRONTO = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  unidade_controle_exp2_if.master bus
);

  localparam int HW = $clog2(CICLOS_PRONTO) + 1;
  localparam logic [HW-1:0] HOLD_LAST = HW'(CICLOS_PRONTO - 1);

  typedef enum logic [3:0] {
    INICIAL = 4'd0,
    PREPARA = 4'd1,
    CARREGA = 4'd2,
    CONTA   = 4'd3,
    ACHOU   = 4'd4,
    ESGOTOU = 4'd5
  } estado_t;

  estado_t        estado_q, estado_d;
  logic           modo_q, modo_d;
  logic [HW-1:0]  hold_q, hold_d;

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      estado_q <= INICIAL;
      modo_q   <= 1'b0;
      hold_q   <= '0;
    end else begin
      estado_q <= estado_d;
      modo_q   <= modo_d;
      hold_q   <= hold_d;
    end
  end

  // hold_d defaults to zero, so the hold counter is already clear on entry to ACHOU/ESGOTOU.
  always_comb begin
    estado_d = estado_q;
    modo_d   = modo_q;
    hold_d   = '0;
    case (estado_q)
      INICIAL: begin
        if (bus.iniciar) begin
          modo_d   = bus.modo;
          estado_d = PREPARA;
        end
      end
      PREPARA: estado_d = modo_q ? CARREGA : CONTA;
      CARREGA: estado_d = CONTA;
      CONTA: begin
        if (!modo_q && bus.igual) begin
          estado_d = ACHOU;
        end else if (bus.fim) begin
          estado_d = ESGOTOU;
        end
      end
      ACHOU, ESGOTOU: begin
        if (hold_q == HOLD_LAST) begin
          estado_d = INICIAL;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      default: estado_d = INICIAL;
    endcase
  end

  // In load mode igual is meaningless, so only rco stops the count.
  assign bus.conta     = (estado_q == CONTA) & ~bus.fim & (modo_q | ~bus.igual);
  assign bus.zera      = (estado_q == PREPARA);
  assign bus.carrega   = (estado_q == CARREGA);
  assign bus.pronto    = (estado_q == ACHOU) | (estado_q == ESGOTOU);
  assign bus.achou     = (estado_q == ACHOU);
  assign bus.db_estado = estado_q;

  a_excl: assert property (@(posedge clock) disable iff (!reset_n)
    !((bus.zera && bus.carrega) || (bus.zera && bus.conta) || (bus.carrega && bus.conta)));

endmodule

// File: tb/tb_unidade_controle_exp2.sv
// Drives two control units (CICLOS_PRONTO 1 and 3) against behavioural datapaths; a monitor scores each completed run.
module tb_unidade_controle_exp2;

  typedef struct {
    int achou;
    int estado;
    int cnt;
    int n_zera;
    int n_carrega;
    int n_conta;
    int plen;
    int gap;
  } exp_t;

  logic clock = 1'b0;
  logic reset_n = 1'b0;
  always #5 clock = ~clock;

  unidade_controle_exp2_if bus1();
  unidade_controle_exp2_if bus3();

  unidade_controle_exp2 #(.CICLOS_PRONTO(1)) dut1 (.clock(clock), .reset_n(reset_n), .bus(bus1));
  unidade_controle_exp2 #(.CICLOS_PRONTO(3)) dut3 (.clock(clock), .reset_n(reset_n), .bus(bus3));

  logic [3:0] cnt1 = 4'd0, cnt3 = 4'd0;
  logic [3:0] ch1 = 4'd0, ch3 = 4'd0;

  always @(posedge clock) begin
    if (bus1.zera) cnt1 <= 4'd0;
    else if (bus1.carrega) cnt1 <= ch1;
    else if (bus1.conta) cnt1 <= cnt1 + 4'd1;
  end
  always @(posedge clock) begin
    if (bus3.zera) cnt3 <= 4'd0;
    else if (bus3.carrega) cnt3 <= ch3;
    else if (bus3.conta) cnt3 <= cnt3 + 4'd1;
  end
  assign bus1.fim   = (cnt1 == 4'd15);
  assign bus1.igual = (cnt1 == ch1);
  assign bus3.fim   = (cnt3 == 4'd15);
  assign bus3.igual = (cnt3 == ch3);

  exp_t exp1_q[$];
  exp_t exp3_q[$];

  int total = 0, bad = 0;
  int n_zera[2], n_carrega[2], n_conta[2], plen[2], idle[2], idle_snap[2], done[2];
  logic prev_pronto[2];
  logic [3:0] prev_est[2], snap_est[2], snap_cnt[2];
  logic snap_achou[2];
  logic final_chk = 1'b0, mon_done = 1'b0;

  task automatic chk(input string nm, input int act, input int expv);
    total++;
    if (act != expv) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, expv);
    end
  endtask

  task automatic clr(input int k);
    n_zera[k] = 0; n_carrega[k] = 0; n_conta[k] = 0; plen[k] = 0;
  endtask

  task automatic mon(input int k, input logic rn, input logic zera, input logic carrega,
                     input logic conta, input logic pronto, input logic achou,
                     input logic [3:0] est, input logic [3:0] cnt);
    exp_t e;
    if (!rn) begin
      chk($sformatf("reset_outputs%0d", k), {zera, carrega, conta, pronto, achou, est}, 0);
      clr(k);
      idle[k] = 0; prev_pronto[k] = 1'b0; prev_est[k] = 4'd0;
    end else begin
      chk($sformatf("exclusive%0d", k), (zera & carrega) | (zera & conta) | (carrega & conta), 0);
      if (est != 4'd0 && prev_est[k] == 4'd0) idle_snap[k] = idle[k];
      if (est == 4'd0) idle[k]++;
      n_zera[k] += int'(zera);
      n_carrega[k] += int'(carrega);
      n_conta[k] += int'(conta);
      if (pronto) begin
        if (!prev_pronto[k]) begin
          snap_est[k] = est; snap_cnt[k] = cnt; snap_achou[k] = achou;
        end
        plen[k]++;
      end else if (prev_pronto[k]) begin
        if ((k == 0 && exp1_q.size() == 0) || (k == 1 && exp3_q.size() == 0)) begin
          total++; bad++;
          $display("FAIL unexpected_result%0d: got a completed run expected none", k);
        end else begin
          e = (k == 0) ? exp1_q.pop_front() : exp3_q.pop_front();
          chk($sformatf("achou%0d", k), snap_achou[k], e.achou);
          chk($sformatf("estado%0d", k), snap_est[k], e.estado);
          chk($sformatf("count%0d", k), snap_cnt[k], e.cnt);
          chk($sformatf("zera_cycles%0d", k), n_zera[k], e.n_zera);
          chk($sformatf("carrega_cycles%0d", k), n_carrega[k], e.n_carrega);
          chk($sformatf("conta_cycles%0d", k), n_conta[k], e.n_conta);
          chk($sformatf("pronto_cycles%0d", k), plen[k], e.plen);
          chk($sformatf("back_to_inicial%0d", k), est, 0);
          if (e.gap >= 0) chk($sformatf("inicial_gap%0d", k), idle_snap[k], e.gap);
        end
        done[k]++;
        clr(k);
        idle[k] = 1;
      end
      prev_pronto[k] = pronto;
      prev_est[k] = est;
    end
  endtask

  initial begin
    for (int k = 0; k < 2; k++) begin
      clr(k); idle[k] = 0; idle_snap[k] = 0; done[k] = 0;
      prev_pronto[k] = 1'b0; prev_est[k] = 4'd0;
    end
    forever begin
      @(negedge clock);
      mon(0, reset_n, bus1.zera, bus1.carrega, bus1.conta, bus1.pronto, bus1.achou, bus1.db_estado, cnt1);
      mon(1, reset_n, bus3.zera, bus3.carrega, bus3.conta, bus3.pronto, bus3.achou, bus3.db_estado, cnt3);
      if (final_chk && !mon_done) begin
        chk("pending_dut1", exp1_q.size(), 0);
        chk("pending_dut3", exp3_q.size(), 0);
        mon_done = 1'b1;
      end
    end
  end

  task automatic wait_done(input int k, input int target);
    for (int i = 0; i < 200 && done[k] < target; i++) @(posedge clock);
  endtask

  task automatic run1(input logic m, input logic [3:0] ch, input exp_t e);
    ch1 = ch;
    bus1.modo = m;
    exp1_q.push_back(e);
    bus1.iniciar = 1'b1;
    @(posedge clock); #1;
    bus1.iniciar = 1'b0;
    wait_done(0, done[0] + 1);
    repeat (2) @(posedge clock);
    #1;
  endtask

  initial begin
    exp_t e;
    bus1.iniciar = 1'b0; bus1.modo = 1'b0;
    bus3.iniciar = 1'b0; bus3.modo = 1'b0;
    repeat (3) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (2) @(posedge clock);
    #1;

    // {achou, estado, cnt, zera, carrega, conta, pronto_len, gap}
    e = '{1, 4, 5, 1, 0, 5, 1, -1};   run1(1'b0, 4'd5, e);
    e = '{1, 4, 0, 1, 0, 0, 1, -1};   run1(1'b0, 4'd0, e);
    e = '{1, 4, 15, 1, 0, 15, 1, -1}; run1(1'b0, 4'd15, e);
    e = '{0, 5, 15, 1, 1, 3, 1, -1};  run1(1'b1, 4'd12, e);

    // Abort a search at count 4 with an asynchronous reset; no result is expected.
    ch1 = 4'd9; bus1.modo = 1'b0; bus1.iniciar = 1'b1;
    @(posedge clock); #1 bus1.iniciar = 1'b0;
    for (int i = 0; i < 40 && cnt1 != 4'd4; i++) begin
      @(posedge clock); #1;
    end
    reset_n = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
    repeat (6) @(posedge clock);
    #1;

    e = '{1, 4, 7, 1, 0, 7, 1, -1};   run1(1'b0, 4'd7, e);

    // Back-to-back runs with iniciar held high on the CICLOS_PRONTO=3 unit.
    ch3 = 4'd2; bus3.modo = 1'b0;
    e = '{1, 4, 2, 1, 0, 2, 3, -1}; exp3_q.push_back(e);
    e = '{1, 4, 2, 1, 0, 2, 3, 1};  exp3_q.push_back(e);
    bus3.iniciar = 1'b1;
    for (int i = 0; i < 40 && bus3.db_estado != 4'd3; i++) begin
      @(posedge clock); #1;
    end
    bus3.modo = 1'b1;
    @(posedge clock); #1 bus3.modo = 1'b0;
    wait_done(1, 1);
    for (int i = 0; i < 40 && bus3.db_estado != 4'd1; i++) begin
      @(posedge clock); #1;
    end
    bus3.iniciar = 1'b0;
    wait_done(1, 2);
    repeat (3) @(posedge clock);
    #1 final_chk = 1'b1;
    for (int i = 0; i < 5 && !mon_done; i++) @(posedge clock);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
